// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I/RV64I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencing with registered decode.
// Optional retired-instruction counter port instret enabled by `define MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl #(
  parameter int XLEN    = 64,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               ifu_finish,
  input  logic               exu_finish,
  input  logic               memu_finish,
  output logic               ifu_valid,
  output logic               idu_valid,
  output logic               exu_valid,
  output logic               memu_valid,
  output logic               wb_valid,
  output logic [4:0]         rs1addr,
  output logic [4:0]         rs2addr,
  output logic [4:0]         rdaddr,
  output logic [XLEN-1:0]    imm,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_a_sel,
  output logic [1:0]         alu_b_sel,
  output logic [1:0]         br_sel,
  output logic [2:0]         wb_sel,
  output logic               rf_we,
  output logic               dm_re,
  output logic               dm_we,
  output logic               mem_unsigned,
  output logic [1:0]         mem_size,
  output logic               illegal,
  output logic               retire
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  ,
  output logic [63:0]        instret
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [ALUOP_W-1:0] A_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_AND   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] A_XOR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] A_SLT   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] A_SLTU  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] A_SLL   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] A_SRL   = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] A_SRA   = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] A_PASSB = ALUOP_W'(20);

  localparam bit RV64 = (XLEN == 64);

  logic [2:0]         state_q, state_d;
  logic               ld_q, st_q, br_q;
  logic [4:0]         rd_q;
  logic [XLEN-1:0]    imm_q;
  logic [ALUOP_W-1:0] aop_q;
  logic [1:0]         asel_q, bsel_q, brs_q, msize_q;
  logic [2:0]         wbs_q;
  logic               mu_q, dmre_q, dmwe_q, retire_q;
  logic               retire_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        shamt_ok;

  logic               dec_legal, dec_ld, dec_st, dec_br, dec_mu;
  logic [4:0]         dec_rd;
  logic [31:0]        dec_imm;
  logic [ALUOP_W-1:0] dec_op;
  logic [1:0]         dec_asel, dec_bsel, dec_brs, dec_msize;
  logic [2:0]         dec_wbs;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // RV32 has only 5-bit shift amounts, so instr[25] must be clear there.
  assign shamt_ok = RV64 || !instr[25];

  always_comb begin
    dec_legal = 1'b0;
    dec_ld    = 1'b0;
    dec_st    = 1'b0;
    dec_br    = 1'b0;
    dec_mu    = 1'b0;
    dec_rd    = instr[11:7];
    dec_imm   = '0;
    dec_op    = A_ADD;
    dec_asel  = 2'd0;
    dec_bsel  = 2'd0;
    dec_brs   = 2'd0;
    dec_msize = 2'd0;
    dec_wbs   = 3'd0;
    case (opc)
      OP_LUI:   begin dec_legal = 1'b1; dec_imm = imm_u; dec_op = A_PASSB; dec_bsel = 2'd1; end
      OP_AUIPC: begin dec_legal = 1'b1; dec_imm = imm_u; dec_asel = 2'd1; dec_bsel = 2'd1; end
      OP_JAL: begin
        dec_legal = 1'b1; dec_imm = imm_j; dec_asel = 2'd1; dec_bsel = 2'd3; dec_brs = 2'd1;
      end
      OP_JALR: begin
        dec_legal = (f3 == 3'd0); dec_imm = imm_i; dec_asel = 2'd1; dec_bsel = 2'd3; dec_brs = 2'd2;
      end
      OP_BRANCH: begin
        dec_legal = (f3[2:1] != 2'b01);
        dec_br    = 1'b1;
        dec_rd    = '0;
        dec_imm   = imm_b;
        dec_brs   = 2'd3;
        dec_op    = !f3[2] ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
      end
      OP_LOAD: begin
        case (f3)
          3'd0, 3'd1, 3'd2, 3'd4, 3'd5: dec_legal = 1'b1;
          3'd3, 3'd6:                   dec_legal = RV64;
          default:                      dec_legal = 1'b0;
        endcase
        dec_ld = 1'b1; dec_imm = imm_i; dec_bsel = 2'd1; dec_wbs = 3'd4;
        dec_msize = f3[1:0]; dec_mu = f3[2];
      end
      OP_STORE: begin
        dec_legal = !f3[2] && (RV64 || f3 != 3'd3);
        dec_st = 1'b1; dec_rd = '0; dec_imm = imm_s; dec_bsel = 2'd1; dec_msize = f3[1:0];
      end
      OP_IMM: begin
        dec_imm   = imm_i;
        dec_bsel  = 2'd1;
        dec_legal = 1'b1;
        case (f3)
          3'd0: dec_op = A_ADD;
          3'd2: dec_op = A_SLT;
          3'd3: dec_op = A_SLTU;
          3'd4: dec_op = A_XOR;
          3'd6: dec_op = A_OR;
          3'd7: dec_op = A_AND;
          3'd1: begin
            dec_legal = (instr[31:26] == 6'b000000) && shamt_ok;
            dec_op = A_SLL; dec_bsel = 2'd2;
          end
          default: begin
            dec_legal = (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000) && shamt_ok;
            dec_op = instr[30] ? A_SRA : A_SRL; dec_bsel = 2'd2;
          end
        endcase
      end
      OP_REG: begin
        dec_legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0:    dec_op = f7[5] ? A_SUB : A_ADD;
          3'd1:    dec_op = A_SLL;
          3'd2:    dec_op = A_SLT;
          3'd3:    dec_op = A_SLTU;
          3'd4:    dec_op = A_XOR;
          3'd5:    dec_op = f7[5] ? A_SRA : A_SRL;
          3'd6:    dec_op = A_OR;
          default: dec_op = A_AND;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      S_FETCH:  if (ifu_finish) state_d = S_DECODE;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: if (exu_finish) begin
        if (ld_q || st_q) state_d = S_MEM;
        else if (br_q) begin state_d = S_FETCH; retire_d = 1'b1; end
        else state_d = S_WB;
      end
      S_MEM: if (memu_finish) begin
        state_d  = ld_q ? S_WB : S_FETCH;
        retire_d = !ld_q;
      end
      S_WB:    begin state_d = S_FETCH; retire_d = 1'b1; end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      br_q     <= 1'b0;
      rd_q     <= '0;
      imm_q    <= '0;
      aop_q    <= '0;
      asel_q   <= '0;
      bsel_q   <= '0;
      brs_q    <= '0;
      wbs_q    <= '0;
      msize_q  <= '0;
      mu_q     <= 1'b0;
      dmre_q   <= 1'b0;
      dmwe_q   <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
      dmre_q   <= (state_q == S_EXEC) && exu_finish && ld_q;
      dmwe_q   <= (state_q == S_EXEC) && exu_finish && st_q;
      if (state_q == S_DECODE && dec_legal) begin
        ld_q    <= dec_ld;
        st_q    <= dec_st;
        br_q    <= dec_br;
        rd_q    <= dec_rd;
        imm_q   <= XLEN'($signed(dec_imm));
        aop_q   <= dec_op;
        asel_q  <= dec_asel;
        bsel_q  <= dec_bsel;
        brs_q   <= dec_brs;
        wbs_q   <= dec_wbs;
        msize_q <= dec_msize;
        mu_q    <= dec_mu;
      end
    end
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk) begin
    if (rst)           instret_q <= '0;
    else if (retire_d) instret_q <= instret_q + 64'd1;
  end
  assign instret = instret_q;
`endif

  // TRAP is reported as a decode-stage cycle so exactly one valid stays high.
  assign ifu_valid    = (state_q == S_FETCH);
  assign idu_valid    = (state_q == S_DECODE) || (state_q == S_TRAP);
  assign exu_valid    = (state_q == S_EXEC);
  assign memu_valid   = (state_q == S_MEM);
  assign wb_valid     = (state_q == S_WB);
  assign illegal      = (state_q == S_TRAP);
  assign rf_we        = (state_q == S_WB) && (rd_q != 5'd0);
  assign rs1addr      = instr[19:15];
  assign rs2addr      = instr[24:20];
  assign rdaddr       = rd_q;
  assign imm          = imm_q;
  assign alu_op       = aop_q;
  assign alu_a_sel    = asel_q;
  assign alu_b_sel    = bsel_q;
  assign br_sel       = brs_q;
  assign wb_sel       = wbs_q;
  assign mem_size     = msize_q;
  assign mem_unsigned = mu_q;
  assign dm_re        = dmre_q;
  assign dm_we        = dmwe_q;
  assign retire       = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: XLEN=64 and XLEN=32 instances driven one at a time, checked
// against an instruction-level decode model and per-stage sequencing expectations.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_WB = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4;

  typedef struct {
    int          kind;
    logic [63:0] imm;
    int          aop, asel, bsel, brs, wbs, rd, ms, mu;
  } dec_t;

  logic        rst_a [2];
  logic [31:0] instr_a [2];
  logic        ifu_f [2], exu_f [2], mem_f [2];
  logic        ifu_v [2], idu_v [2], exu_v [2], mem_v [2], wb_v [2];
  logic [4:0]  rs1_a [2], rs2_a [2], rd_a [2], aop_a [2];
  logic [1:0]  as_a [2], bs_a [2], br_a [2], ms_a [2];
  logic [2:0]  wbs_a [2];
  logic        rfwe_a [2], dmre_a [2], dmwe_a [2], mu_a [2], ill_a [2], ret_a [2];
  logic [63:0] imm64;
  logic [31:0] imm32;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [63:0] instret64;
  logic [63:0] exp_instret = '0;
`endif

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.XLEN(64), .ALUOP_W(5)) d64 (
    .clk(clk), .rst(rst_a[0]), .instr(instr_a[0]),
    .ifu_finish(ifu_f[0]), .exu_finish(exu_f[0]), .memu_finish(mem_f[0]),
    .ifu_valid(ifu_v[0]), .idu_valid(idu_v[0]), .exu_valid(exu_v[0]),
    .memu_valid(mem_v[0]), .wb_valid(wb_v[0]),
    .rs1addr(rs1_a[0]), .rs2addr(rs2_a[0]), .rdaddr(rd_a[0]), .imm(imm64),
    .alu_op(aop_a[0]), .alu_a_sel(as_a[0]), .alu_b_sel(bs_a[0]), .br_sel(br_a[0]),
    .wb_sel(wbs_a[0]), .rf_we(rfwe_a[0]), .dm_re(dmre_a[0]), .dm_we(dmwe_a[0]),
    .mem_unsigned(mu_a[0]), .mem_size(ms_a[0]), .illegal(ill_a[0]), .retire(ret_a[0])
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .instret(instret64)
`endif
  );

  multicycle_ctrl #(.XLEN(32), .ALUOP_W(5)) d32 (
    .clk(clk), .rst(rst_a[1]), .instr(instr_a[1]),
    .ifu_finish(ifu_f[1]), .exu_finish(exu_f[1]), .memu_finish(mem_f[1]),
    .ifu_valid(ifu_v[1]), .idu_valid(idu_v[1]), .exu_valid(exu_v[1]),
    .memu_valid(mem_v[1]), .wb_valid(wb_v[1]),
    .rs1addr(rs1_a[1]), .rs2addr(rs2_a[1]), .rdaddr(rd_a[1]), .imm(imm32),
    .alu_op(aop_a[1]), .alu_a_sel(as_a[1]), .alu_b_sel(bs_a[1]), .br_sel(br_a[1]),
    .wb_sel(wbs_a[1]), .rf_we(rfwe_a[1]), .dm_re(dmre_a[1]), .dm_we(dmwe_a[1]),
    .mem_unsigned(mu_a[1]), .mem_size(ms_a[1]), .illegal(ill_a[1]), .retire(ret_a[1])
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .instret()
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] imm_of(input int s);
    return (s == 0) ? imm64 : {{32{imm32[31]}}, imm32};
  endfunction

  function automatic longint fld(input logic [31:0] v, input int hi, input int lo);
    return longint'((v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  // Reference decode: immediates built by weighted field arithmetic, legality by rule.
  function automatic dec_t model(input logic [31:0] i, input bit x64);
    dec_t   d;
    int     f3, top6;
    longint neg, vi, vs, vb, vu, vj;
    int     rmap [8];
    int     imap [8];
    rmap = '{0, 7, 5, 6, 4, 8, 3, 2};
    imap = '{0, 7, 5, 6, 4, 8, 3, 2};
    f3   = int'(i[14:12]);
    top6 = int'(i[31:26]);
    neg  = i[31] ? -1 : 0;
    vi = neg * 2048 + fld(i, 30, 20);
    vs = neg * 2048 + fld(i, 30, 25) * 32 + fld(i, 11, 7);
    vb = neg * 4096 + fld(i, 7, 7) * 2048 + fld(i, 30, 25) * 32 + fld(i, 11, 8) * 2;
    vu = neg * (longint'(1) << 31) + fld(i, 30, 12) * 4096;
    vj = neg * (longint'(1) << 20) + fld(i, 19, 12) * 4096 + fld(i, 20, 20) * 2048 + fld(i, 30, 21) * 2;
    d = '{kind: K_ILL, imm: 64'd0, aop: 0, asel: 0, bsel: 0, brs: 0, wbs: 0,
          rd: int'(i[11:7]), ms: 0, mu: 0};
    case (i[6:0])
      7'h37: begin d.kind = K_WB; d.imm = vu; d.aop = 20; d.bsel = 1; end
      7'h17: begin d.kind = K_WB; d.imm = vu; d.asel = 1; d.bsel = 1; end
      7'h6f: begin d.kind = K_WB; d.imm = vj; d.asel = 1; d.bsel = 3; d.brs = 1; end
      7'h67: if (f3 == 0) begin d.kind = K_WB; d.imm = vi; d.asel = 1; d.bsel = 3; d.brs = 2; end
      7'h63: if (f3 != 2 && f3 != 3) begin
        d.kind = K_BR; d.imm = vb; d.brs = 3; d.rd = 0;
        d.aop = (f3 < 4) ? 1 : ((f3 < 6) ? 5 : 6);
      end
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5 || (x64 && (f3 == 3 || f3 == 6))) begin
        d.kind = K_LD; d.imm = vi; d.bsel = 1; d.wbs = 4; d.ms = f3 % 4; d.mu = f3 / 4;
      end
      7'h23: if (f3 < 3 || (x64 && f3 == 3)) begin
        d.kind = K_ST; d.imm = vs; d.bsel = 1; d.ms = f3; d.rd = 0;
      end
      7'h13: begin
        d.imm = vi;
        if (f3 == 1 || f3 == 5) begin
          if ((top6 == 0 || (f3 == 5 && top6 == 16)) && (x64 || !i[25])) begin
            d.kind = K_WB; d.bsel = 2; d.aop = (top6 == 16) ? 9 : imap[f3];
          end
        end else begin
          d.kind = K_WB; d.bsel = 1; d.aop = imap[f3];
        end
      end
      7'h33: begin
        if (i[31:25] == 7'h00) begin d.kind = K_WB; d.aop = rmap[f3]; end
        else if (i[31:25] == 7'h20 && f3 == 0) begin d.kind = K_WB; d.aop = 1; end
        else if (i[31:25] == 7'h20 && f3 == 5) begin d.kind = K_WB; d.aop = 9; end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [9];
    int          p;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    r = $urandom;
    p = $urandom_range(0, 10);
    if (p < 9) r[6:0] = ops[p];
    if ($urandom_range(0, 1) == 1) r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
    return r;
  endfunction

  task automatic expect_retire(input int s);
    chk("retire", ret_a[s], 1);
    chk("retire_fetch", ifu_v[s], 1);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    if (s == 0) begin
      exp_instret = exp_instret + 64'd1;
      chk("instret", instret64, exp_instret);
    end
`endif
  endtask

  // Starts and ends at a negedge with the selected DUT in FETCH.
  task automatic run_instr(input int s, input logic [31:0] ins, input int dif, input int dex, input int dmem);
    dec_t e;
    e = model(ins, s == 0);
    instr_a[s] = ins;
    for (int k = 0; k <= dif; k++) begin
      chk("fetch_valid", ifu_v[s], 1);
      if (k > 0) chk("retire_idle", ret_a[s], 0);
      ifu_f[s] = (k == dif);
      exu_f[s] = 1'($urandom);
      mem_f[s] = 1'($urandom);
      @(negedge clk);
    end
    ifu_f[s] = 1'b0;
    chk("decode_valid", idu_v[s], 1);
    chk("decode_onehot", 32'(ifu_v[s]) + 32'(exu_v[s]) + 32'(mem_v[s]) + 32'(wb_v[s]), 0);
    chk("rs1addr", rs1_a[s], ins[19:15]);
    chk("rs2addr", rs2_a[s], ins[24:20]);
    @(negedge clk);
    if (e.kind == K_ILL) begin
      chk("trap_illegal", ill_a[s], 1);
      chk("trap_no_exec", exu_v[s], 0);
      chk("trap_rf_we", rfwe_a[s], 0);
      chk("trap_dm", {dmre_a[s], dmwe_a[s]}, 0);
      exu_f[s] = 1'b0; mem_f[s] = 1'b0;
      @(negedge clk);
      chk("trap_to_fetch", ifu_v[s], 1);
      chk("trap_no_retire", ret_a[s], 0);
      chk("trap_illegal_end", ill_a[s], 0);
      return;
    end
    chk("no_illegal", ill_a[s], 0);
    for (int k = 0; k <= dex; k++) begin
      chk("exec_valid", exu_v[s], 1);
      if (k == 0) begin
        chk("imm", imm_of(s), e.imm);
        chk("alu_op", aop_a[s], e.aop);
        chk("alu_a_sel", as_a[s], e.asel);
        chk("alu_b_sel", bs_a[s], e.bsel);
        chk("br_sel", br_a[s], e.brs);
        chk("wb_sel", wbs_a[s], e.wbs);
        chk("rdaddr", rd_a[s], e.rd);
        chk("mem_size", ms_a[s], e.ms);
        chk("mem_unsigned", mu_a[s], e.mu);
      end
      exu_f[s] = (k == dex);
      mem_f[s] = 1'($urandom);
      @(negedge clk);
    end
    if (e.kind == K_BR) begin
      exu_f[s] = 1'b0; mem_f[s] = 1'b0;
      expect_retire(s);
      return;
    end
    if (e.kind == K_LD || e.kind == K_ST) begin
      for (int k = 0; k <= dmem; k++) begin
        chk("mem_valid", mem_v[s], 1);
        chk("dm_re", dmre_a[s], (k == 0 && e.kind == K_LD));
        chk("dm_we", dmwe_a[s], (k == 0 && e.kind == K_ST));
        chk("mem_rf_we", rfwe_a[s], 0);
        exu_f[s] = 1'($urandom);
        mem_f[s] = (k == dmem);
        @(negedge clk);
      end
      if (e.kind == K_ST) begin
        exu_f[s] = 1'b0; mem_f[s] = 1'b0;
        expect_retire(s);
        return;
      end
    end
    chk("wb_valid", wb_v[s], 1);
    chk("wb_rf_we", rfwe_a[s], (e.rd != 0));
    chk("wb_no_retire_yet", ret_a[s], 0);
    exu_f[s] = 1'b0; mem_f[s] = 1'b0;
    @(negedge clk);
    expect_retire(s);
    chk("fetch_rf_we", rfwe_a[s], 0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_a[s] = 1'b1; instr_a[s] = '0; ifu_f[s] = 1'b0; exu_f[s] = 1'b0; mem_f[s] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_fetch", ifu_v[s], 1);
      chk("rst_imm", imm_of(s), 0);
      chk("rst_alu_op", aop_a[s], 0);
      chk("rst_rdaddr", rd_a[s], 0);
      chk("rst_sels", {as_a[s], bs_a[s], br_a[s], wbs_a[s], ms_a[s]}, 0);
      chk("rst_pulses", {ret_a[s], ill_a[s], rfwe_a[s], dmre_a[s], dmwe_a[s]}, 0);
    end
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    chk("rst_instret", instret64, 0);
`endif
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(negedge clk);

    run_instr(0, 32'h00500093, 0, 0, 0);
    chk("addi_imm_held", imm_of(0), 64'd5);
    chk("addi_bsel_held", bs_a[0], 1);
    run_instr(0, 32'h0080B183, 1, 2, 3);
    chk("ld_size", ms_a[0], 3);
    chk("ld_wbsel", wbs_a[0], 4);
    run_instr(0, 32'h0020B423, 0, 1, 0);
    chk("sd_imm", imm_of(0), 64'd8);
    run_instr(0, 32'h00000000, 0, 0, 0);
    run_instr(1, 32'h0080B183, 0, 0, 0);
    run_instr(1, 32'h4010D093, 0, 0, 0);
    run_instr(1, 32'h4210D093, 0, 0, 0);
    run_instr(0, 32'h4210D093, 0, 0, 0);
    run_instr(0, 32'hFE208EE3, 2, 0, 0);

    instr_a[1] = 32'h123450B7;
    ifu_f[1] = 1'b1;
    @(negedge clk);
    ifu_f[1] = 1'b0;
    @(negedge clk);
    chk("lui_exec", exu_v[1], 1);
    chk("lui_imm", imm_of(1), 64'h12345000);
    chk("lui_alu_op", aop_a[1], 20);
    rst_a[1] = 1'b1;
    @(negedge clk);
    chk("abort_fetch", ifu_v[1], 1);
    chk("abort_no_retire", ret_a[1], 0);
    chk("abort_imm", imm_of(1), 0);
    rst_a[1] = 1'b0;
    @(negedge clk);
    chk("abort_idle", {ret_a[1], rfwe_a[1], dmwe_a[1], ill_a[1]}, 0);
    chk("abort_stay_fetch", ifu_v[1], 1);

    for (int n = 0; n < 300; n++) begin
      run_instr(n % 2, rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    force d64.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release d64.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int n = 0; n < 3; n++) run_instr(0, 32'h00500093, 0, 0, 0);
    chk("instret_wrap", instret64, 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 (RV32I) and 64 (RV64I).
REQ-002 Parameter ALUOP_W, default 5, width of alu_op.
REQ-003 Port clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Ports instr (in, 32) and ifu_finish, exu_finish, memu_finish (in, 1 each): current instruction and per-stage completion strobes.
REQ-006 Ports ifu_valid, idu_valid, exu_valid, memu_valid, wb_valid (out, 1 each): stage-active indicators, exactly one high per cycle.
REQ-007 Ports rs1addr, rs2addr (out, 5, combinational from instr) and rdaddr (out, 5, registered).
REQ-008 Port imm (out, XLEN): registered sign-extended immediate.
REQ-009 Ports alu_op (out, ALUOP_W), alu_a_sel, alu_b_sel, br_sel (out, 2 each), wb_sel (out, 3): registered datapath selects.
REQ-010 Ports rf_we, dm_re, dm_we, mem_unsigned (out, 1 each) and mem_size (out, 2; 0=B, 1=H, 2=W, 3=D).
REQ-011 Ports illegal and retire (out, 1 each): single-cycle event pulses.

Function
REQ-012 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-013 Transitions:
- FETCH->DECODE on ifu_finish.
- DECODE->EXEC, or DECODE->TRAP when the instruction is illegal.
- EXEC->MEM on exu_finish for loads and stores; EXEC->WB on exu_finish otherwise; branches go EXEC->FETCH.
- MEM->WB on memu_finish for loads; MEM->FETCH on memu_finish for stores.
- WB->FETCH and TRAP->FETCH unconditionally after one cycle.
REQ-014 A state waiting on a finish strobe stays in that state indefinitely while the strobe is low; the matching *_valid output stays high throughout.
REQ-015 Decode fields (rdaddr, imm, alu_op, all selects, mem_size, mem_unsigned) are captured once, on the DECODE->EXEC edge, and held stable until the next DECODE.
REQ-016 Decoded set:
- RV32I base ALU, branch, jal, jalr, lui and auipc.
- Loads lb/lh/lw/lbu/lhu and stores sb/sh/sw.
- With XLEN=64 only: ld, lwu, sd, and 6-bit shamt shifts.
REQ-017 Any other encoding is illegal. With XLEN=32 this includes ld, lwu, sd and shift-immediates with instr[25]=1.
REQ-018 Immediates: I, S, B, U and J formats, sign-extended from instr[31] to XLEN. U-type is instr[31:12]<<12, sign-extended.
REQ-019 alu_op encodings: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9, pass-B 20.
REQ-020 alu_a_sel: 0=rs1, 1=pc. alu_b_sel: 0=rs2, 1=imm, 2=shamt, 3=constant 4.
REQ-021 br_sel: 0=pc+4, 1=jal, 2=jalr, 3=conditional branch.
REQ-022 wb_sel: 0=ALU, 4=memory.
REQ-023 dm_re / dm_we: high for the first MEM cycle only (one-cycle pulse), even if memu_finish arrives later.
REQ-024 rf_we: high only during WB, and only when rdaddr != 0.
REQ-025 retire: pulses one cycle on every transition into FETCH from WB, MEM (store) or EXEC (branch); never from TRAP.
REQ-026 illegal: pulses during the single TRAP cycle; no register or memory write occurs for a trapped instruction.
REQ-027 A finish strobe asserted in a state that does not consume it is ignored.

Reset
REQ-028 While rst is high at a clock edge, state loads FETCH and all registered outputs load 0, including imm, selects, mem_size, rdaddr and instret.
REQ-029 Reset asserted mid-instruction (any state) aborts the instruction: no retire, rf_we, dm_we or illegal pulse follows.

Configuration
REQ-030 Macro MULTICYCLE_CTRL_INSTRET_EN, when defined:
- adds output port instret (64 bits), reset to 0;
- instret increments by 1 on each retire pulse and wraps from 2^64-1 to 0.
REQ-031 Without MULTICYCLE_CTRL_INSTRET_EN the instret port and its counter do not exist; all other behaviour is identical.

Verification
REQ-032 XLEN=64, instr=0x00500093 (addi x1,x0,5), finish strobes immediate -> FETCH, DECODE, EXEC, WB, FETCH; imm=5; alu_b_sel=1; rf_we high in WB only; one retire pulse.
REQ-033 instr=0x0080B183 (ld x3,8(x1)), memu_finish delayed 3 cycles -> dm_re high in first MEM cycle only; mem_size=3; memu_valid high 4 cycles; then WB with wb_sel=4.
REQ-034 instr=0x0020B423 (sd x2,8(x1)) -> imm=8, dm_we one-cycle pulse, MEM->FETCH with retire, no WB state.
REQ-035 instr=0x00000000, and separately XLEN=32 with ld 0x0080B183 -> DECODE->TRAP, illegal pulse, no rf_we/dm_*, no retire, next state FETCH.
REQ-036 XLEN=32, instr=0x123450B7 (lui) -> imm=0x12345000, alu_op=20; rst asserted during EXEC -> FETCH next cycle, no retire.
REQ-037 With MULTICYCLE_CTRL_INSTRET_EN, instret preloaded near 2^64-1, then 3 addi retirements -> counter wraps through 0 to 1 (or to the exact value implied by the preload).
